// File: rtl/tf32div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tf32div_seq
// Purpose  : Sequential TF32 divider. Takes FP32-encoded operands, uses only
//            the sign, the exponent and the top MANT_BITS fraction bits, and
//            produces an FP32-encoded truncated quotient. Restoring radix-2
//            division, one quotient bit per cycle, behind valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module tf32div_seq #(
    parameter int MANT_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        div_by_zero,
    output logic        invalid
);

    localparam int c_n     = MANT_BITS + 1;
    localparam int c_pad   = 23 - MANT_BITS;
    localparam int c_cnt_w = $clog2(c_n + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_div  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_n-1:0]     r_mb;
    logic [c_n-1:0]     r_q;
    logic [c_n:0]       r_rem;
    logic [c_cnt_w-1:0] r_count;
    logic [9:0]         r_exp;
    logic               r_sign;
    logic [31:0]        r_p;
    logic               r_dbz;
    logic               r_inv;
    logic               r_out_valid;

    // Operand decode; exp==0 flushes to zero whatever the fraction holds
    logic [7:0]           w_ea, w_eb;
    logic [MANT_BITS-1:0] w_fa, w_fb;
    logic                 w_a_zero, w_b_zero, w_a_max, w_b_max;
    logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_fin_nz;
    logic                 w_sp_nan, w_sp_inf, w_sp_zero, w_sp_dbz, w_special;
    logic                 w_sign, w_adj, w_accept;
    logic [c_n-1:0]       w_ma, w_mb;
    logic [c_n:0]         w_rem_init;
    logic [9:0]           w_exp_init;
    logic [31:0]          w_sp_p;

    assign w_ea       = a[30:23];
    assign w_eb       = b[30:23];
    assign w_fa       = a[22 -: MANT_BITS];
    assign w_fb       = b[22 -: MANT_BITS];
    assign w_a_zero   = (w_ea == 8'h00);
    assign w_b_zero   = (w_eb == 8'h00);
    assign w_a_max    = (w_ea == 8'hFF);
    assign w_b_max    = (w_eb == 8'hFF);
    assign w_a_nan    = w_a_max & (|w_fa);
    assign w_b_nan    = w_b_max & (|w_fb);
    assign w_a_inf    = w_a_max & ~(|w_fa);
    assign w_b_inf    = w_b_max & ~(|w_fb);
    assign w_a_fin_nz = ~w_a_zero & ~w_a_max;
    assign w_sign     = a[31] ^ b[31];

    // Special classes in priority order NaN > inf > zero
    assign w_sp_nan  = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_sp_inf  = ~w_sp_nan & (w_a_inf | (w_a_fin_nz & w_b_zero));
    assign w_sp_dbz  = ~w_sp_nan & w_a_fin_nz & w_b_zero;
    assign w_sp_zero = ~w_sp_nan & ~w_sp_inf & (w_a_zero | w_b_inf);
    assign w_special = w_sp_nan | w_sp_inf | w_sp_zero;
    assign w_sp_p    = w_sp_nan ? {w_sign, 8'hFF, 23'h400000} :
                       w_sp_inf ? {w_sign, 8'hFF, 23'h000000} :
                                  {w_sign, 31'd0};

    // Pre-alignment keeps the quotient MSB at 1, the exponent absorbs the shift
    assign w_ma       = {1'b1, w_fa};
    assign w_mb       = {1'b1, w_fb};
    assign w_adj      = (w_ma < w_mb);
    assign w_rem_init = w_adj ? {w_ma, 1'b0} : {1'b0, w_ma};
    assign w_exp_init = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127 - {9'd0, w_adj};
    assign w_accept   = in_valid & (r_state == c_st_idle);

    // One restoring step per cycle; remainder stays below 2*mB so c_n+1 bits suffice
    logic               w_ge, w_last, w_uf, w_of;
    logic [c_n:0]       w_rem_kept;
    logic [c_n:0]       w_rem_next;
    logic [c_n-1:0]     w_q_next;
    logic [22:0]        w_frac;
    logic [31:0]        w_div_p;

    assign w_ge       = (r_rem >= {1'b0, r_mb});
    assign w_rem_kept = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    assign w_rem_next = {w_rem_kept[c_n-1:0], 1'b0};
    assign w_q_next   = {r_q[c_n-2:0], w_ge};
    assign w_last     = (r_count == c_last);
    assign w_frac     = {w_q_next[c_n-2:0], {c_pad{1'b0}}};
    assign w_uf       = ($signed(r_exp) <= 10'sd0);
    assign w_of       = ($signed(r_exp) >= 10'sd255);
    assign w_div_p    = w_uf ? {r_sign, 31'd0} :
                        w_of ? {r_sign, 8'hFF, 23'd0} :
                               {r_sign, r_exp[7:0], w_frac};

    // Bits that carry no information: ignored fraction LSBs and the always-one quotient MSB
    logic w_unused_bits;
    assign w_unused_bits = ^{a[22-MANT_BITS:0], b[22-MANT_BITS:0], r_q[c_n-1], w_rem_kept[c_n]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_next = w_special ? c_st_done : c_st_div;
            c_st_div:  if (w_last)   w_state_next = c_st_done;
            c_st_done: if (out_ready) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Datapath: capture at accept, iterate in DIV, hold result through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mb        <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_p         <= '0;
            r_dbz       <= 1'b0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_mb    <= w_mb;
                        r_rem   <= w_rem_init;
                        r_q     <= '0;
                        r_count <= '0;
                        r_exp   <= w_exp_init;
                        r_sign  <= w_sign;
                        r_dbz   <= w_sp_dbz;
                        r_inv   <= w_sp_nan;
                        if (w_special) begin
                            r_p         <= w_sp_p;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                c_st_div: begin
                    r_rem   <= w_rem_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + c_cnt_w'(1);
                    if (w_last) begin
                        r_p         <= w_div_p;
                        r_out_valid <= 1'b1;
                    end
                end
                c_st_done: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready    = (r_state == c_st_idle);
    assign out_valid   = r_out_valid;
    assign p           = r_p;
    assign div_by_zero = r_dbz;
    assign invalid     = r_inv;

endmodule
`default_nettype wire
